// File: rtl/clk_en_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_pkg
// Shared constants for the clock-enable generator.
//   NUM_CH_DEF  : default number of divider channels
//   CNT_W_DEF   : default divisor / counter width per channel
//   DEF_DIV_DEF : divisor loaded at reset (100 MHz -> 25 MHz enable)
//   slice_lo()  : low bit index of channel k inside a packed per-channel bus
// -----------------------------------------------------------------------------
package clk_en_pkg;

  localparam int NUM_CH_DEF  = 2;
  localparam int CNT_W_DEF   = 8;
  localparam int DEF_DIV_DEF = 4;

  // Channel k of a packed bus occupies [slice_lo(k, w) +: w].
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// -----------------------------------------------------------------------------
// clk_en_gen_if
// Control and status bundle of the clock-enable generator.
//   en_i     : per-channel count enable
//   sync_i   : global realign strobe (all channels)
//   div_wr_i : per-channel divisor write strobe
//   div_i    : packed divisors, channel k at [k*CNT_W +: CNT_W]
//   tick_o   : per-channel one-cycle clock-enable pulse
//   sq_o     : per-channel 50% square wave
//   pend_o   : per-channel "written divisor not yet applied"
// master = the side that drives controls, slave = the generator.
// -----------------------------------------------------------------------------
interface clk_en_gen_if
  import clk_en_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic [NUM_CH-1:0]       en_i;
  logic                    sync_i;
  logic [NUM_CH-1:0]       div_wr_i;
  logic [NUM_CH*CNT_W-1:0] div_i;
  logic [NUM_CH-1:0]       tick_o;
  logic [NUM_CH-1:0]       sq_o;
  logic [NUM_CH-1:0]       pend_o;

  modport master (
    output en_i, sync_i, div_wr_i, div_i,
    input  tick_o, sq_o, pend_o
  );

  modport slave (
    input  en_i, sync_i, div_wr_i, div_i,
    output tick_o, sq_o, pend_o
  );

endinterface

// File: rtl/clk_en_chan.sv
// -----------------------------------------------------------------------------
// clk_en_chan
// One divider channel. Counts 0..N-1 while enabled (N = act, with 0 and 1
// both meaning N = 1), emits a registered tick when the count is 0 and
// toggles a square wave on every tick. A written divisor is held pending
// and becomes active at the next wrap or sync.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en_i       : count enable
//   sync_i     : realign strobe (force count to 0, apply pending divisor)
//   div_wr_i   : divisor write strobe, div_i : divisor value
//   tick_o     : one-cycle enable pulse, sq_o : square wave
//   pend_o     : a written divisor is waiting to be applied
// -----------------------------------------------------------------------------
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             div_wr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic [CNT_W-1:0] pnd_q, pnd_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  logic [CNT_W-1:0] last_cnt;
  logic             wrap;

  always_comb begin
    // NOTE: every combinational output gets a default first so that no
    // path through the if/else tree leaves it unassigned (no latches).
    cnt_d  = cnt_q;
    act_d  = act_q;
    pnd_d  = pnd_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    sq_d   = sq_q;

    // Divisors 0 and 1 both mean "every cycle", so the last count is 0.
    last_cnt = (act_q <= ONE) ? '0 : act_q - ONE;
    // '>=' rather than '==' keeps the counter bounded even if it ever
    // sits above the last count.
    wrap     = en_i && (cnt_q >= last_cnt);

    // NOTE: blocking assignments here let the write below feed the apply
    // logic in the same cycle, so a write coincident with a wrap or sync
    // takes effect immediately and never shows as pending.
    if (div_wr_i) begin
      pnd_d  = div_i;
      pend_d = 1'b1;
    end

    if (sync_i) begin
      // Sync behaves as a forced wrap with the tick suppressed.
      cnt_d  = '0;
      act_d  = pnd_d;
      pend_d = 1'b0;
    end else if (en_i) begin
      tick_d = (cnt_q == '0);
      sq_d   = sq_q ^ tick_d;
      if (wrap) begin
        cnt_d  = '0;
        act_d  = pnd_d;
        pend_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= RST_DIV;
      pnd_q  <= RST_DIV;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pnd_q  <= pnd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Multi-channel clock-enable generator: NUM_CH independent dividers that
// share only the sync_i realign strobe.
// Ports:
//   clk   : sole system clock (posedge)
//   reset : synchronous active-high reset
//   bus   : clk_en_gen_if.slave (en_i, sync_i, div_wr_i, div_i in;
//           tick_o, sq_o, pend_o out)
// -----------------------------------------------------------------------------
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic         clk,
  input  logic         reset,
  clk_en_gen_if.slave  bus
);

  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] pend;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    localparam int LO = slice_lo(k, CNT_W);

    clk_en_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en_i     (bus.en_i[k]),
      .sync_i   (bus.sync_i),
      .div_wr_i (bus.div_wr_i[k]),
      .div_i    (bus.div_i[LO +: CNT_W]),
      .tick_o   (tick[k]),
      .sq_o     (sq[k]),
      .pend_o   (pend[k])
    );
  end

  assign bus.tick_o = tick;
  assign bus.sq_o   = sq;
  assign bus.pend_o = pend;

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
// Self-checking bench for clk_en_gen (NUM_CH=2, CNT_W=8, DEF_DIV=4).
// Directed table for channel 0, hand-written multi-cycle sequences, then
// random stimulus compared against a period/phase model of each channel.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;

  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;
  localparam int W       = NUM_CH * CNT_W;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  clk_en_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_en_gen #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: each channel tracks how far it is into its current
  // period (phase) and the period length in force; ticks mark phase 0.
  // ---------------------------------------------------------------------------
  int m_phase   [NUM_CH];
  int m_act     [NUM_CH];
  int m_pnd     [NUM_CH];
  bit m_pending [NUM_CH];
  bit m_tick    [NUM_CH];
  bit m_sq      [NUM_CH];

  function automatic int eff_period(input int a);
    return (a < 2) ? 1 : a;
  endfunction

  function automatic void model_update(input logic rst, input logic [NUM_CH-1:0] en,
                                       input logic s, input logic [NUM_CH-1:0] wr,
                                       input logic [W-1:0] d);
    for (int k = 0; k < NUM_CH; k++) begin
      int wdiv;
      wdiv = int'(d[k*CNT_W +: CNT_W]);
      if (rst) begin
        m_phase[k] = 0;  m_act[k] = DEF_DIV;  m_pnd[k] = DEF_DIV;
        m_pending[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
      end else begin
        if (wr[k]) begin
          m_pnd[k] = wdiv;
          m_pending[k] = 1;
        end
        if (s) begin
          m_phase[k] = 0; m_tick[k] = 0;
          m_act[k] = m_pnd[k]; m_pending[k] = 0;
        end else if (en[k]) begin
          m_tick[k] = (m_phase[k] == 0);
          if (m_tick[k]) m_sq[k] = !m_sq[k];
          m_phase[k] = m_phase[k] + 1;
          if (m_phase[k] >= eff_period(m_act[k])) begin
            m_phase[k] = 0; m_act[k] = m_pnd[k]; m_pending[k] = 0;
          end
        end else begin
          m_tick[k] = 0;
        end
      end
    end
  endfunction

  // Apply one cycle of inputs, let the edge happen, advance the model,
  // and return 1 ns after the edge so outputs are stable for sampling.
  task automatic step(input logic rst, input logic [NUM_CH-1:0] en, input logic s,
                      input logic [NUM_CH-1:0] wr, input logic [W-1:0] d);
    reset        = rst;
    bus.en_i     = en;
    bus.sync_i   = s;
    bus.div_wr_i = wr;
    bus.div_i    = d;
    @(posedge clk);
    model_update(rst, en, s, wr, d);
    #1;
  endtask

  function automatic logic [W-1:0] put_div(input int k, input int v);
    logic [W-1:0] r;
    r = '0;
    r[k*CNT_W +: CNT_W] = CNT_W'(v);
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors for channel 0 (channel 1 kept disabled)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       rst;
    logic       en;
    logic       wr;
    logic [7:0] div;
    logic       tick;
    logic       sq;
    logic       pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic en, input logic wr,
                              input int div, input logic tick, input logic sq,
                              input logic pend);
    vec_t v;
    v.rst = rst; v.en = en; v.wr = wr; v.div = 8'(div);
    v.tick = tick; v.sq = sq; v.pend = pend;
    return v;
  endfunction

  initial begin
    logic [NUM_CH-1:0] r_en, r_wr;
    logic [W-1:0]      r_d;
    logic              r_s, r_rst;
    logic [NUM_CH-1:0] e_tick, e_sq, e_pend;

    reset = 1'b1; bus.en_i = '0; bus.sync_i = 1'b0; bus.div_wr_i = '0; bus.div_i = '0;

    //              rst en wr div  tick sq pend
    tbl.push_back(mk(1, 0, 0, 0,   0, 0, 0)); // reset state
    tbl.push_back(mk(0, 1, 0, 0,   1, 1, 0)); // first tick, cycle 1
    tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 3,   0, 1, 1)); // write 3 -> pending
    tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0)); // wrap applies 3
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0)); // cycle 5 tick
    tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,   1, 1, 0)); // every 3 now
    tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,   0, 0, 0)); // disabled: hold
    tbl.push_back(mk(0, 0, 1, 1,   0, 0, 1)); // write 1 while disabled
    tbl.push_back(mk(0, 1, 0, 0,   0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0,   0, 0, 0)); // wrap applies 1
    tbl.push_back(mk(0, 1, 0, 0,   1, 1, 0)); // continuous ticks
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,   1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0,   1, 0, 0)); // write 0 at wrap: no pend
    tbl.push_back(mk(0, 1, 0, 0,   1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0,   1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, {1'b0, tbl[i].en}, 1'b0, {1'b0, tbl[i].wr}, {8'h00, tbl[i].div});
      check($sformatf("tbl[%0d] tick", i), 32'(bus.tick_o[0]), 32'(tbl[i].tick));
      check($sformatf("tbl[%0d] sq",   i), 32'(bus.sq_o[0]),   32'(tbl[i].sq));
      check($sformatf("tbl[%0d] pend", i), 32'(bus.pend_o[0]), 32'(tbl[i].pend));
      check($sformatf("tbl[%0d] ch1 idle", i),
            32'({bus.tick_o[1], bus.sq_o[1], bus.pend_o[1]}), 32'(0));
    end

    // --- Write of 6 coincident with the wrap: never pending, period 6 ---
    step(1, '0, 0, '0, '0);
    for (int c = 0; c < 3; c++) step(0, 2'b01, 0, '0, '0);
    step(0, 2'b01, 0, 2'b01, put_div(0, 6));           // cnt==3: wrap edge
    check("wr_at_wrap pend", 32'(bus.pend_o[0]), 32'(0));
    for (int i = 0; i < 13; i++) begin
      step(0, 2'b01, 0, '0, '0);
      check($sformatf("wr_at_wrap tick i=%0d", i), 32'(bus.tick_o[0]), 32'(i % 6 == 0));
      check($sformatf("wr_at_wrap pend i=%0d", i), 32'(bus.pend_o[0]), 32'(0));
    end

    // --- Sync realigns ch0 (div 4) and ch1 (div 5, applied by sync) ---
    step(1, '0, 0, '0, '0);
    step(0, 2'b11, 0, '0, '0);
    step(0, 2'b11, 0, 2'b10, put_div(1, 5));
    check("sync pre pend", 32'(bus.pend_o), 32'(2'b10));
    step(0, 2'b11, 1, '0, '0);
    check("sync tick", 32'(bus.tick_o), 32'(0));
    check("sync pend", 32'(bus.pend_o), 32'(0));
    for (int i = 0; i < 20; i++) begin
      step(0, 2'b11, 0, '0, '0);
      check($sformatf("post_sync tick i=%0d", i), 32'(bus.tick_o),
            32'({i % 5 == 0, i % 4 == 0}));
    end

    // --- Reset mid-period with a write pending ---
    step(1, '0, 0, '0, '0);
    step(0, 2'b01, 0, '0, '0);
    step(0, 2'b01, 0, '0, '0);
    step(0, 2'b01, 0, 2'b01, put_div(0, 7));
    check("rst_mid pend before", 32'(bus.pend_o[0]), 32'(1));
    step(1, 2'b01, 0, '0, '0);
    check("rst_mid outputs", 32'({bus.tick_o, bus.sq_o, bus.pend_o}), 32'(0));
    for (int i = 0; i < 12; i++) begin
      step(0, 2'b01, 0, '0, '0);
      check($sformatf("rst_mid tick i=%0d", i), 32'(bus.tick_o[0]), 32'(i % 4 == 0));
      check($sformatf("rst_mid pend i=%0d", i), 32'(bus.pend_o[0]), 32'(0));
    end

    // --- Random stimulus against the model ---
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_s   = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        r_en[k] = ($urandom_range(0, 3) != 0);
        r_wr[k] = ($urandom_range(0, 9) == 0);
      end
      r_d = '0;
      for (int k = 0; k < NUM_CH; k++) r_d[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 7));
      step(r_rst, r_en, r_s, r_wr, r_d);
      for (int k = 0; k < NUM_CH; k++) begin
        e_tick[k] = m_tick[k];
        e_sq[k]   = m_sq[k];
        e_pend[k] = m_pending[k];
      end
      check($sformatf("rand tick c=%0d", c), 32'(bus.tick_o), 32'(e_tick));
      check($sformatf("rand sq c=%0d",   c), 32'(bus.sq_o),   32'(e_sq));
      check($sformatf("rand pend c=%0d", c), 32'(bus.pend_o), 32'(e_pend));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent divider channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the divisor and counter width per channel.
REQ-003 The block SHALL have parameter DEF_DIV, default 4, giving the divisor loaded at reset (100 MHz -> 25 MHz enable).
REQ-004 The block SHALL have port clk, input, 1, sole system clock; one clock, all logic on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-006 The block SHALL have port en_i, input, NUM_CH, per-channel count enable.
REQ-007 The block SHALL have port sync_i, input, 1, global realign strobe for all channels.
REQ-008 The block SHALL have port div_wr_i, input, NUM_CH, per-channel divisor write strobe.
REQ-009 The block SHALL have port div_i, input, NUM_CH*CNT_W, packed divisors, channel k at bits [k*CNT_W +: CNT_W].
REQ-010 The block SHALL have port tick_o, output, NUM_CH, registered one-cycle clock-enable pulse per channel.
REQ-011 The block SHALL have port sq_o, output, NUM_CH, registered 50% square wave per channel.
REQ-012 The block SHALL have port pend_o, output, NUM_CH, high while a written divisor awaits application.

Function
REQ-013 Each channel SHALL hold counter cnt (CNT_W bits), active divisor act, pending divisor pnd, and a pending flag.
REQ-014 Effective period N SHALL be act, except that act values 0 and 1 both give N=1.
REQ-015 While en_i[k]=1, cnt SHALL count 0,1,...,N-1,0 (wrap at N-1, never beyond).
REQ-016 tick_o[k] SHALL be registered as (en_i[k] && cnt==0): high exactly one cycle in every N enabled cycles, first tick one cycle after the first enabled edge following reset.
REQ-017 sq_o[k] SHALL toggle on every edge where tick_o[k] is set, giving period 2N and 50% duty.
REQ-018 While en_i[k]=0, cnt and sq_o[k] SHALL hold, and tick_o[k] SHALL be 0.
REQ-019 On div_wr_i[k]=1, div_i slice SHALL be captured into pnd and pend_o[k] SHALL go high on the next cycle.
REQ-020 pnd SHALL be copied to act, and pend_o[k] SHALL clear, on the edge where an enabled cnt wraps from N-1 to 0.
REQ-021 A write in the same cycle as a wrap SHALL take effect at that wrap, and pend_o SHALL stay 0.
REQ-022 A second write before application SHALL overwrite pnd; only the last value applies.
REQ-023 sync_i=1 SHALL force every cnt to 0, apply any pending divisor, and force tick_o to 0 that cycle; counting SHALL resume from 0 next cycle, so the first post-sync tick appears 1 cycle after sync_i deasserts.
REQ-024 Priority SHALL be reset > sync_i > div write/apply > counting.
REQ-025 Channels SHALL be fully independent apart from sync_i.

Reset
REQ-026 On reset, every cnt SHALL be 0, act and pnd SHALL be DEF_DIV, and tick_o, sq_o and pend_o SHALL all be 0.
REQ-027 A reset asserted mid-period or with a write pending SHALL discard the pending divisor and restart from the REQ-026 state.

Structure
REQ-028 Package clk_en_pkg SHALL hold the default CNT_W, the DEF_DIV constant and the packed-slice helper constants.
REQ-029 One sub-module, clk_en_chan, SHALL implement a single channel, instantiated NUM_CH times via generate.
REQ-030 The top level SHALL contain only slicing, generate and the sync_i fan-out.

Verification
REQ-031 Reset, then en=1 with DEF_DIV=4 -> tick_o high at cycles 1, 5, 9, ...; sq_o period 8.
REQ-032 Write div=3 at cycle 2 -> pend_o=1 until the wrap at cycle 4; ticks then occur every 3 cycles.
REQ-033 Write div=0 and div=1 -> tick_o stays high continuously once applied; sq_o toggles every cycle.
REQ-034 Write div=6 with the write coincident with the wrap -> pend_o never asserts; next period is 6.
REQ-035 Channels at div=4 and div=5, pulse sync_i for 1 cycle -> both tick 1 cycle after sync_i deasserts, then every 4 and every 5 cycles respectively.
REQ-036 Pulse reset mid-period with a write pending -> all outputs 0 next cycle, pend_o=0, period restored to 4.
